// File: rtl/riscv_uop_pkg.sv
// Shared micro-op types for the issue stage: the decoded uop record, the
// register scoreboard vector and the source-operand match helper.
package riscv_uop_pkg;

  localparam int ISSUE_DEPTH = 4;

  typedef logic [31:0] sb_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_op;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } uop_t;

  // x0 is never a real dependency, so it never matches.
  function automatic logic uop_reads_reg(uop_t u, logic [4:0] r);
    return (r != 5'd0) &&
           ((u.uses_rs1 && (u.rs1 == r)) || (u.uses_rs2 && (u.rs2 == r)));
  endfunction

endpackage

// File: rtl/riscv_issue_queue_if.sv
// Decode-side, issue-side, writeback and debug signals of the issue queue.
interface riscv_issue_queue_if #(
  parameter int CNT_W = $clog2(riscv_uop_pkg::ISSUE_DEPTH) + 1
);
  import riscv_uop_pkg::*;

  logic             flush;
  logic             dec_valid;
  logic             dec_ready;
  uop_t             dec_uop;
  logic             iss_valid;
  logic             iss_ready;
  uop_t             iss_uop;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [CNT_W-1:0] count;
  sb_t              sb_busy;

  modport master (
    output flush, dec_valid, dec_uop, iss_ready, wb_valid, wb_rd,
    input  dec_ready, iss_valid, iss_uop, count, sb_busy
  );

  modport slave (
    input  flush, dec_valid, dec_uop, iss_ready, wb_valid, wb_rd,
    output dec_ready, iss_valid, iss_uop, count, sb_busy
  );

endinterface

// File: rtl/riscv_scoreboard.sv
// 32-entry register busy vector with one set port, one clear port and a
// combinational hazard query for a single uop.
module riscv_scoreboard
  import riscv_uop_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_en_i,
  input  logic [4:0] clr_idx_i,
  input  logic       set_en_i,
  input  logic [4:0] set_idx_i,
  input  uop_t       query_uop_i,
  output logic       hazard_o,
  output sb_t        busy_o
);

  sb_t busy_q, busy_d;

  // Set is applied after clear so an issue and a writeback to the same
  // register in one cycle leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    hazard_o = 1'b0;
    for (int unsigned r = 1; r < 32; r++) begin
      if (busy_q[r] &&
          (uop_reads_reg(query_uop_i, 5'(r)) ||
           (query_uop_i.writes_rd && (query_uop_i.rd == 5'(r)))))
        hazard_o = 1'b1;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/riscv_issue_queue.sv
// In-order issue queue: circular FIFO of decoded uops, head released only
// when the scoreboard reports no RAW/WAW hazard.
module riscv_issue_queue
  import riscv_uop_pkg::*;
#(
  parameter int DEPTH = ISSUE_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic               clk,
  input logic               rst,
  riscv_issue_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  uop_t             mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, push, pop, hazard, iss_valid;
  uop_t             head;
  sb_t              sb_busy;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign head      = empty ? '0 : mem_q[rd_ptr_q];
  assign iss_valid = !empty && !hazard;

  // Flush suppresses both handshakes even though iss_valid stays visible.
  assign push = bus.dec_valid && !full && !bus.flush;
  assign pop  = iss_valid && bus.iss_ready && !bus.flush;

  assign bus.dec_ready = !full;
  assign bus.iss_valid = iss_valid;
  assign bus.iss_uop   = head;
  assign bus.count     = count_q;
  assign bus.sb_busy   = sb_busy;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.dec_uop;
  end

  riscv_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .clr_en_i    (bus.wb_valid),
    .clr_idx_i   (bus.wb_rd),
    .set_en_i    (pop && head.writes_rd && (head.rd != 5'd0)),
    .set_idx_i   (head.rd),
    .query_uop_i (head),
    .hazard_o    (hazard),
    .busy_o      (sb_busy)
  );

endmodule

// File: doc/riscv_issue_queue.md
Name: riscv_issue_queue

Overview:
- In-order issue stage directly downstream of the decoder.
- Accepts decoded uop_t micro-ops over a valid/ready handshake and buffers them in a small FIFO.
- Tracks pending destination registers in a 32-bit scoreboard.
- Releases the head uop to the execute stage only when none of its source or destination registers are busy.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, ≥2).
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  discard all queued (not yet issued) uops.
- dec_valid  in  1  decoder offers dec_uop.
- dec_ready  out  1  queue can accept; equals !full.
- dec_uop  in  $bits(uop_t)  decoded micro-op.
- iss_valid  out  1  head uop is issuable.
- iss_ready  in  1  execute accepts the head uop.
- iss_uop  out  $bits(uop_t)  head-of-queue uop.
- wb_valid  in  1  writeback completes.
- wb_rd  in  5  register being written back; clears its scoreboard bit.
- count  out  CNT_W  current occupancy.
- sb_busy  out  32  scoreboard state, for debug and verification.

Behaviour:
Reset (asynchronous, active-high):
- rd_ptr, wr_ptr, count and scoreboard all go to 0.
- Outputs: dec_ready=1, iss_valid=0, count=0, sb_busy=0, iss_uop=0.
- A reset mid-operation drops all entries and all pending registers immediately.

Handshakes:
- Enqueue when dec_valid && dec_ready. Pop when iss_valid && iss_ready.
- dec_ready depends only on registered count, so there is no combinational path from iss_ready.
- When full, no enqueue happens even if a pop occurs in the same cycle.

Storage:
- Circular buffer with pointers of width $clog2(DEPTH); pointers wrap modulo DEPTH.
- count is incremented on enqueue only, decremented on pop only, and unchanged when both happen.

Latency:
- A uop enqueued into an empty queue in cycle N appears on iss_uop/iss_valid in cycle N+1. There is no bypass.

Hazard logic (combinational on the head entry and the registered scoreboard):
- raw1 = uses_rs1 && rs1!=0 && sb[rs1]
- raw2 = uses_rs2 && rs2!=0 && sb[rs2]
- waw = writes_rd && rd!=0 && sb[rd]
- iss_valid = !empty && !(raw1 || raw2 || waw)
- iss_uop always shows the head entry, and 0 when empty.
- Head uops with uop.valid=0 are still queued and issued; execute raises the illegal-instruction trap.

Scoreboard update (per cycle):
- Clear sb[wb_rd] if wb_valid.
- Then set sb[iss_uop.rd] if pop && writes_rd && rd!=0. When both target the same register, the set wins.
- sb[0] is always 0.
- The scoreboard is read from registered state only. A writeback in cycle N unblocks a dependent head in cycle N+1.
- A wb_valid to a register that is not busy is a no-op.

Flush:
- Next cycle: rd_ptr=wr_ptr=0 and count=0.
- The scoreboard is preserved, because already-issued uops still write back.
- Flush overrides enqueue and pop in the same cycle: neither occurs, and iss_valid is still presented but the pop is ignored.
- The execute stage must also ignore anything issued in the flush cycle.

Decomposition:
- Add to riscv_uop_pkg:
  - ISSUE_DEPTH (default 4)
  - typedef logic [31:0] sb_t
  - function uop_reads_reg(uop_t, logic [4:0]) for the hazard test.
- Sub-module riscv_scoreboard:
  - Holds the 32-bit busy vector with its set and clear ports.
  - Provides a combinational hazard query for one uop.
  - Reused later by a dual-issue variant.
- The FIFO stays inline.

Test Plan:
1. Reset, then enqueue ADDI rd=5 rs1=0 at cycle 1 with iss_ready=1 -> iss_valid=1 at cycle 2; after the pop sb_busy=32'h20 and count=0.
2. With sb[5] busy, enqueue ADD rd=6 rs1=5 rs2=1 -> iss_valid stays 0; assert wb_valid, wb_rd=5 in cycle N -> iss_valid=1 in N+1, and after the pop sb_busy=32'h40.
3. Hold iss_ready=0 and offer 5 back-to-back uops -> dec_ready drops after the 4th, count=4; release iss_ready -> the uops issue in order, and the pointers wrap cleanly over 3 refills.
4. Same cycle: wb_valid with wb_rd=7, plus a pop of a uop with rd=7 -> sb[7] ends at 1.
5. Queue 3 entries with sb[9] busy, then flush while dec_valid=1 -> next cycle count=0, iss_valid=0, sb_busy=32'h200, and the offered uop is dropped.
6. Head uop with rd=0, writes_rd=1, rs1=0 -> issues without stalling; sb_busy stays 0 and repeated wb_rd=0 has no effect.
